// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO, runtime baud prescaler,
// optional parity and 1/2 stop bits. Serial line idles high.
module uart_tx_fifo_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [DATA_WIDTH-1:0]  i_p_data,
    input  logic                   i_data_valid,
    input  logic                   i_par_en,
    input  logic                   i_par_typ,
    input  logic                   i_stop2,
    input  logic [PRESC_WIDTH-1:0] i_prescale,
    output logic                   o_tx_out,
    output logic                   o_busy,
    output logic                   o_fifo_full,
    output logic                   o_fifo_empty,
    output logic                   o_overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_overrun;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_parity;
    logic                   r_par_en;
    logic                   r_stop2;
    logic                   r_stop_cnt;
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [PRESC_WIDTH-1:0] r_presc_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_tx;
    logic                   r_busy;

    logic [PRESC_WIDTH-1:0] w_presc_in;
    logic                   w_tick;
    logic                   w_frame_end;
    logic                   w_pop;
    logic                   w_push;
    logic [CNT_W-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0]  w_head;

    assign w_presc_in  = (i_prescale == '0) ? PRESC_WIDTH'(1) : i_prescale;
    assign w_tick      = (r_presc_cnt == '0);
    assign w_frame_end = (r_state == S_STOP) && w_tick && (!r_stop2 || r_stop_cnt);
    assign w_pop       = !r_empty && ((r_state == S_IDLE) || w_frame_end);
    // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
    assign w_push      = i_data_valid && (!r_full || w_pop);
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_p_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count   <= w_count_next;
            r_full    <= (w_count_next == CNT_W'(FIFO_DEPTH));
            r_empty   <= (w_count_next == '0);
            r_overrun <= i_data_valid && r_full && !w_pop;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_cnt  <= 1'b0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else if (w_pop) begin
            // Frame start: word and line configuration are frozen for the whole frame.
            r_state     <= S_START;
            r_shift     <= w_head;
            r_parity    <= (^w_head) ^ i_par_typ;
            r_par_en    <= i_par_en;
            r_stop2     <= i_stop2;
            r_stop_cnt  <= 1'b0;
            r_presc     <= w_presc_in;
            r_presc_cnt <= w_presc_in - PRESC_WIDTH'(1);
            r_bit_cnt   <= '0;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_tick) begin
                        r_state     <= S_DATA;
                        r_tx        <= r_shift[0];
                        r_bit_cnt   <= '0;
                        r_presc_cnt <= r_presc - PRESC_WIDTH'(1);
                    end else begin
                        r_presc_cnt <= r_presc_cnt - PRESC_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_presc_cnt <= r_presc - PRESC_WIDTH'(1);
                        if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                            r_tx    <= r_par_en ? r_parity : 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_tx      <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_presc_cnt <= r_presc_cnt - PRESC_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_state     <= S_STOP;
                        r_tx        <= 1'b1;
                        r_presc_cnt <= r_presc - PRESC_WIDTH'(1);
                    end else begin
                        r_presc_cnt <= r_presc_cnt - PRESC_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_presc_cnt <= r_presc - PRESC_WIDTH'(1);
                        if (r_stop2 && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_presc_cnt <= r_presc_cnt - PRESC_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_out     = r_tx;
    assign o_busy       = r_busy;
    assign o_fifo_full  = r_full;
    assign o_fifo_empty = r_empty;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: directed cases plus random frames, line activity
// is logged per clock and compared against frames built from the word and config.
module tb_uart_tx_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] p_data;
    logic       valid8, valid7;
    logic       par_en, par_typ, stop2;
    logic [7:0] prescale;

    logic tx8, busy8, full8, empty8, ovr8;
    logic tx7, busy7, full7, empty7, ovr7;

    int tests = 0;
    int fails = 0;

    bit   sel;
    bit   rec_en;
    bit   tx_log[$];
    bit   busy_log[$];
    logic [8:0] exp_words[$];

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_p_data(p_data[7:0]), .i_data_valid(valid8),
        .i_par_en(par_en), .i_par_typ(par_typ), .i_stop2(stop2), .i_prescale(prescale),
        .o_tx_out(tx8), .o_busy(busy8), .o_fifo_full(full8), .o_fifo_empty(empty8),
        .o_overrun(ovr8)
    );

    uart_tx_fifo_param #(.DATA_WIDTH(7), .FIFO_DEPTH(4), .PRESC_WIDTH(8)) u_dut7 (
        .i_clk(clk), .i_rst_n(rst_n), .i_p_data(p_data[6:0]), .i_data_valid(valid7),
        .i_par_en(par_en), .i_par_typ(par_typ), .i_stop2(stop2), .i_prescale(prescale),
        .o_tx_out(tx7), .o_busy(busy7), .o_fifo_full(full7), .o_fifo_empty(empty7),
        .o_overrun(ovr7)
    );

    always @(negedge clk) begin
        if (rec_en) begin
            tx_log.push_back(sel ? tx7 : tx8);
            busy_log.push_back(sel ? busy7 : busy8);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] d, input bit to7);
        p_data = d;
        if (to7) valid7 = 1'b1;
        else     valid8 = 1'b1;
        @(negedge clk);
        valid7 = 1'b0;
        valid8 = 1'b0;
    endtask

    task automatic start_rec();
        tx_log.delete();
        busy_log.delete();
        rec_en = 1'b1;
    endtask

    // Expected line: each queued word becomes start, data LSB first, optional
    // parity, stop bit(s), every bit held p clocks, frames back to back, then idle.
    task automatic check_log(input string tag, input int dw, input bit pe, input bit pt,
                             input bit s2, input int p);
        bit exp_q[$];
        int start;
        int busy_ones;
        int exp_busy_ones;
        int ones;
        bit b;
        bit e_tx;
        bit e_busy;
        exp_busy_ones = 0;
        foreach (exp_words[k]) begin
            ones = 0;
            repeat (p) exp_q.push_back(1'b0);
            for (int i = 0; i < dw; i++) begin
                b = exp_words[k][i];
                ones += int'(b);
                repeat (p) exp_q.push_back(b);
            end
            if (pe) begin
                b = ((ones % 2) != 0) ^ pt;
                repeat (p) exp_q.push_back(b);
            end
            repeat ((s2 ? 2 : 1) * p) exp_q.push_back(1'b1);
            exp_busy_ones += p * (2 + dw + int'(pe) + int'(s2));
        end
        start = -1;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (tx_log[i] == 1'b0) begin
                start = i;
                break;
            end
        end
        check({tag, "_start_found"}, 32'(start >= 0), 32'd1);
        check({tag, "_log_len"}, 32'(tx_log.size() > start + exp_q.size()), 32'd1);
        if (start >= 0) begin
            for (int i = 0; i < tx_log.size(); i++) begin
                if (i >= start && (i - start) < exp_q.size()) begin
                    e_tx   = exp_q[i - start];
                    e_busy = 1'b1;
                end else begin
                    e_tx   = 1'b1;
                    e_busy = 1'b0;
                end
                check($sformatf("%s_line_busy_cyc%0d", tag, i),
                      {30'd0, tx_log[i], busy_log[i]}, {30'd0, e_tx, e_busy});
            end
        end
        busy_ones = 0;
        foreach (busy_log[i]) busy_ones += int'(busy_log[i]);
        check({tag, "_busy_clocks"}, busy_ones, exp_busy_ones);
    endtask

    initial begin
        logic [8:0] w;
        logic [8:0] burst [5];
        int n;
        int p_eff;

        rst_n    = 1'b0;
        p_data   = '0;
        valid8   = 1'b0;
        valid7   = 1'b0;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stop2    = 1'b0;
        prescale = 8'd1;
        sel      = 1'b0;
        rec_en   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", tx8, 1);
        check("rst_busy", busy8, 0);
        check("rst_full", full8, 0);
        check("rst_empty", empty8, 1);
        check("rst_overrun", ovr8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 0x55, even parity, prescale 1, plus first-word latency
        par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = 8'd1;
        start_rec();
        push(9'h055, 1'b0);
        check("t1_empty_after_push", empty8, 0);
        check("t1_tx_before_pop", tx8, 1);
        check("t1_busy_before_pop", busy8, 0);
        @(negedge clk);
        check("t1_tx_start", tx8, 0);
        check("t1_busy_start", busy8, 1);
        check("t1_empty_after_pop", empty8, 1);
        repeat (20) @(negedge clk);
        rec_en = 1'b0;
        exp_words = '{9'h055};
        check_log("t1", 8, 1'b1, 1'b0, 1'b0, 1);

        // 2: odd parity, two stop bits, prescale 4 (48-clock frame)
        par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; prescale = 8'd4;
        start_rec();
        push(9'h057, 1'b0);
        repeat (60) @(negedge clk);
        rec_en = 1'b0;
        exp_words = '{9'h057};
        check_log("t2", 8, 1'b1, 1'b1, 1'b1, 4);

        // 3: three words pushed back to back, no parity
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 8'd2;
        start_rec();
        push(9'h0A3, 1'b0);
        push(9'h00F, 1'b0);
        push(9'h0FF, 1'b0);
        repeat (75) @(negedge clk);
        rec_en = 1'b0;
        exp_words = '{9'h0A3, 9'h00F, 9'h0FF};
        check_log("t3", 8, 1'b0, 1'b0, 1'b0, 2);

        // 4: fill the FIFO behind an active frame, sixth push overruns
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 8'd4;
        burst = '{9'h012, 9'h034, 9'h056, 9'h078, 9'h09A};
        start_rec();
        push(9'h0FF, 1'b0);
        @(negedge clk);
        check("t4_busy_in_flight", busy8, 1);
        for (int k = 1; k <= 5; k++) begin
            p_data = burst[k-1];
            valid8 = 1'b1;
            @(negedge clk);
            check($sformatf("t4_full_push%0d", k + 1), full8, (k >= 4) ? 1 : 0);
            check($sformatf("t4_overrun_push%0d", k + 1), ovr8, (k == 5) ? 1 : 0);
        end
        valid8 = 1'b0;
        @(negedge clk);
        check("t4_overrun_pulse_end", ovr8, 0);
        check("t4_still_full", full8, 1);
        repeat (230) @(negedge clk);
        rec_en = 1'b0;
        exp_words = '{9'h0FF, 9'h012, 9'h034, 9'h056, 9'h078};
        check_log("t4", 8, 1'b0, 1'b0, 1'b0, 4);

        // 5: reset during data bits with two words queued
        par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = 8'd2;
        push(9'h0AA, 1'b0);
        push(9'h0BB, 1'b0);
        push(9'h0CC, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_busy_before_rst", busy8, 1);
        check("t5_empty_before_rst", empty8, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx8, 1);
        check("t5_rst_busy", busy8, 0);
        check("t5_rst_empty", empty8, 1);
        check("t5_rst_full", full8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_rec();
        repeat (60) @(negedge clk);
        rec_en = 1'b0;
        check("t5_log_len", 32'(busy_log.size() >= 55), 1);
        foreach (tx_log[i]) begin
            check($sformatf("t5_idle_cyc%0d", i), {30'd0, tx_log[i], busy_log[i]}, 32'b10);
        end

        // 6: 7-bit instance, prescale 0 behaves as 1
        sel = 1'b1;
        par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0; prescale = 8'd0;
        start_rec();
        push(9'h035, 1'b1);
        push(9'h04A, 1'b1);
        repeat (30) @(negedge clk);
        rec_en = 1'b0;
        exp_words = '{9'h035, 9'h04A};
        check_log("t6", 7, 1'b1, 1'b1, 1'b0, 1);
        check("t6_dut8_idle", tx8, 1);
        sel = 1'b0;

        // Random words and line configurations
        for (int it = 0; it < 10; it++) begin
            par_en   = 1'($urandom_range(0, 1));
            par_typ  = 1'($urandom_range(0, 1));
            stop2    = 1'($urandom_range(0, 1));
            prescale = 8'($urandom_range(0, 3));
            p_eff    = (prescale == 0) ? 1 : int'(prescale);
            n        = int'($urandom_range(1, 3));
            exp_words.delete();
            start_rec();
            for (int j = 0; j < n; j++) begin
                w = 9'($urandom_range(0, 255));
                exp_words.push_back(w);
                push(w, 1'b0);
            end
            repeat (n * p_eff * 13 + 10) @(negedge clk);
            rec_en = 1'b0;
            check_log($sformatf("rnd%0d", it), 8, par_en, par_typ, stop2, p_eff);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
